// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: fetch/decode sequencer between the program ROM and the execute stage.
// Latency: address -> ROM wait -> decode -> issue; instr_valid rises on the 3rd edge after reset release, so one instruction takes 4 cycles minimum.
// Backpressure: the issued instruction is held stable in S_ISSUE until instr_ready; a redirect or reset discards it.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   pc_addr                       registered ROM address (always equals the internal pc)
//   mem_data                      ROM registered output, valid one cycle after pc_addr
//   instr_valid / instr_ready     issue handshake toward execute
//   opcode, operand               high / low nibble of the instruction byte
//   is_imm, is_jump, is_alu       decode flags (LDI, JMP, ADD/SUB/AND/CMP)
//   redirect_valid/redirect_addr  PC load from execute, ignored once halted
//   halt                          program end reached, sticky until rst
//   instr_count                   accepted-instruction counter, present only with INSTR_COUNT_EN defined
module instr_fetch_seq #(
    parameter int ADDR_W   = 8,
    parameter int PROG_LEN = 28,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc_addr,
    input  logic [7:0]        mem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic              is_imm,
    output logic              is_jump,
    output logic              is_alu,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halt
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0]       instr_count
`endif
);

    localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);
    // One extra bit so a PROG_LEN of 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   PROG_END = (ADDR_W+1)'(PROG_LEN);

    typedef enum logic [2:0] {
        S_ADDR   = 3'd0,
        S_WAIT   = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [7:0]        ir, ir_nxt;
    logic              valid_nxt;
    logic              halt_nxt;
    logic              dec_ld;
    logic              imm_d, jump_d, alu_d;

    assign pc_addr = pc;

    // Decode flags straight from the captured instruction byte.
    always_comb begin
        imm_d  = (ir[7:4] == 4'b1111);
        jump_d = (ir[7:4] == 4'b1001);
        alu_d  = (ir[7:4] == 4'b0001) || (ir[7:4] == 4'b0010) ||
                 (ir[7:4] == 4'b0011) || (ir[7:4] == 4'b0110);
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        valid_nxt = instr_valid;
        halt_nxt  = halt;
        dec_ld    = 1'b0;
        case (state)
            S_ADDR: begin
                if ({1'b0, pc} >= PROG_END) begin
                    state_nxt = S_HALT;
                    halt_nxt  = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                ir_nxt    = mem_data;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                dec_ld    = 1'b1;
                valid_nxt = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                // instr_valid is always set here, so ready alone completes the handshake.
                if (instr_ready) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = S_ADDR;
                end
            end
            S_HALT: begin
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = S_ADDR;
                valid_nxt = 1'b0;
            end
        endcase
        // Redirect overrides everything except halt, including a coincident handshake
        // (the instruction is still consumed, but pc takes the redirect target, not pc+1).
        if (redirect_valid && (state != S_HALT)) begin
            pc_nxt    = redirect_addr;
            valid_nxt = 1'b0;
            halt_nxt  = 1'b0;
            dec_ld    = 1'b0;
            state_nxt = S_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_ADDR;
            pc          <= PC_RST;
            ir          <= 8'h00;
            instr_valid <= 1'b0;
            halt        <= 1'b0;
            opcode      <= 4'h0;
            operand     <= 4'h0;
            is_imm      <= 1'b0;
            is_jump     <= 1'b0;
            is_alu      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            ir          <= ir_nxt;
            instr_valid <= valid_nxt;
            halt        <= halt_nxt;
            // Decoded outputs only change on the decode edge; they hold otherwise.
            if (dec_ld) begin
                opcode  <= ir[7:4];
                operand <= ir[3:0];
                is_imm  <= imm_d;
                is_jump <= jump_d;
                is_alu  <= alu_d;
            end
        end
    end

`ifdef INSTR_COUNT_EN
    logic hs;
    assign hs = (state == S_ISSUE) && instr_valid && instr_ready;

    // Counts every accepted handshake, including one that coincides with a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= 16'h0000;
        end else if (hs && (instr_count != 16'hFFFF)) begin
            instr_count <= instr_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: directed scenarios followed by a randomized run against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: drives random instr_ready and redirects; inputs change on the falling edge.
module tb_instr_fetch_seq;

    localparam int PLEN = 28;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc_addr;
    logic [7:0] mem_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       is_imm, is_jump, is_alu;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic       halt;
`ifdef INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    always #5 clk = ~clk;

    instr_fetch_seq #(.ADDR_W(8), .PROG_LEN(PLEN), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_addr        (pc_addr),
        .mem_data       (mem_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .opcode         (opcode),
        .operand        (operand),
        .is_imm         (is_imm),
        .is_jump        (is_jump),
        .is_alu         (is_alu),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt           (halt)
`ifdef INSTR_COUNT_EN
        ,
        .instr_count    (instr_count)
`endif
    );

    // Program ROM with a registered read port.
    logic [7:0] rom [0:255];
    always @(posedge clk) mem_data <= rom[pc_addr];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // {is_imm, is_jump, is_alu} expected for an instruction byte.
    function automatic logic [2:0] flags_of(input logic [7:0] b);
        logic [3:0] op;
        op = b[7:4];
        flags_of[2] = (op == 4'd15);
        flags_of[1] = (op == 4'd9);
        flags_of[0] = (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd6);
    endfunction

    task automatic check_instr(input string tag, input int addr);
        logic [7:0] b;
        logic [2:0] f;
        b = rom[addr];
        f = flags_of(b);
        check({tag, "_valid"},   32'(instr_valid), 32'd1);
        check({tag, "_opcode"},  32'(opcode),      32'(b[7:4]));
        check({tag, "_operand"}, 32'(operand),     32'(b[3:0]));
        check({tag, "_imm"},     32'(is_imm),      32'(f[2]));
        check({tag, "_jump"},    32'(is_jump),     32'(f[1]));
        check({tag, "_alu"},     32'(is_alu),      32'(f[0]));
        check({tag, "_pc"},      32'(pc_addr),     32'(addr));
    endtask

    // Entered when the DUT sits in the address cycle for addr; leaves it at the issue cycle.
    task automatic run_fetch(input string tag, input int addr);
        check({tag, "_pc0"}, 32'(pc_addr), 32'(addr));
        check({tag, "_v0"},  32'(instr_valid), 32'd0);
        tick();
        check({tag, "_pc1"}, 32'(pc_addr), 32'(addr));
        check({tag, "_v1"},  32'(instr_valid), 32'd0);
        tick();
        check({tag, "_pc2"}, 32'(pc_addr), 32'(addr));
        check({tag, "_v2"},  32'(instr_valid), 32'd0);
        tick();
        check_instr(tag, addr);
    endtask

    int   exp_pc;
    int   exp_cnt;
    int   oob;
    logic r_rst, r_rdy, r_rv, hs;
    logic [7:0] r_ra;
    logic [2:0] rf;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[0] = 8'hF1;
        rom[1] = 8'hD1;
        rom[2] = 8'hF8;
        rom[3] = 8'h11;
        rom[4] = 8'h9F;
        rom[5] = 8'hFF;

        rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
        tick();
        tick();
        check("rst_pc",      32'(pc_addr),     32'd0);
        check("rst_valid",   32'(instr_valid), 32'd0);
        check("rst_opcode",  32'(opcode),      32'd0);
        check("rst_operand", 32'(operand),     32'd0);
        check("rst_flags",   32'({is_imm, is_jump, is_alu}), 32'd0);
        check("rst_halt",    32'(halt),        32'd0);
`ifdef INSTR_COUNT_EN
        check("rst_count",   32'(instr_count), 32'd0);
`endif

        // Basic issue with ready tied high: 4 cycles per instruction.
        rst = 1'b0; instr_ready = 1'b1;
        run_fetch("t1_a0", 0);
        tick();
        run_fetch("t1_a1", 1);
        tick();

        // Backpressure on addr 2: instruction held 5 cycles.
        instr_ready = 1'b0;
        run_fetch("t2_a2", 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_instr("t2_hold", 2);
        end
        instr_ready = 1'b1;
        tick();
        check("t2_next_pc",    32'(pc_addr),     32'd3);
        check("t2_next_valid", 32'(instr_valid), 32'd0);
        run_fetch("t1_a3", 3);
        tick();

        // Redirect coincident with the handshake of JMP at addr 4.
        run_fetch("t5_a4", 4);
        redirect_valid = 1'b1; redirect_addr = 8'd0;
        tick();
        redirect_valid = 1'b0;
        check("t5_pc",    32'(pc_addr),     32'd0);
        check("t5_valid", 32'(instr_valid), 32'd0);
`ifdef INSTR_COUNT_EN
        check("t5_count", 32'(instr_count), 32'd5);
`endif
        run_fetch("t5_a0", 0);
        tick();
        run_fetch("t3_a1", 1);
        tick();
        run_fetch("t3_a2", 2);
        tick();

        // Redirect during the ROM wait of addr 3: that byte never issues.
        check("t3_pc3", 32'(pc_addr), 32'd3);
        tick();
        redirect_valid = 1'b1; redirect_addr = 8'd5;
        tick();
        redirect_valid = 1'b0;
        check("t3_pc",    32'(pc_addr),     32'd5);
        check("t3_valid", 32'(instr_valid), 32'd0);
        run_fetch("t3_a5", 5);

        // Reset while an instruction is being offered.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", 32'(instr_valid), 32'd0);
        check("t6_pc",    32'(pc_addr),     32'd0);
`ifdef INSTR_COUNT_EN
        check("t6_count", 32'(instr_count), 32'd0);
`endif
        run_fetch("t6_a0", 0);
        tick();

        // Run off the end of the program: last valid address issues, the next halts.
        redirect_valid = 1'b1; redirect_addr = 8'(PLEN - 2);
        tick();
        redirect_valid = 1'b0;
        run_fetch("t4_a26", PLEN - 2);
        tick();
        run_fetch("t4_a27", PLEN - 1);
        tick();
        check("t4_pc_end",   32'(pc_addr), 32'(PLEN));
        check("t4_halt_pre", 32'(halt),    32'd0);
        tick();
        check("t4_halt", 32'(halt), 32'd1);
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i % 2 == 0); redirect_addr = 8'd2;
            tick();
            check("t4_hold_valid", 32'(instr_valid), 32'd0);
            check("t4_hold_halt",  32'(halt),        32'd1);
            check("t4_hold_pc",    32'(pc_addr),     32'(PLEN));
        end
        redirect_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_rst_halt", 32'(halt),    32'd0);
        check("t4_rst_pc",   32'(pc_addr), 32'd0);

        // Randomized run: model tracks only the program counter and the accepted count.
        exp_pc = 0; exp_cnt = 0; oob = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            check("r_pc", 32'(pc_addr), 32'(exp_pc));
`ifdef INSTR_COUNT_EN
            check("r_count", 32'(instr_count), 32'(exp_cnt));
`endif
            if (instr_valid) begin
                rf = flags_of(rom[exp_pc]);
                check("r_opcode",  32'(opcode),  32'(rom[exp_pc][7:4]));
                check("r_operand", 32'(operand), 32'(rom[exp_pc][3:0]));
                check("r_flags",   32'({is_imm, is_jump, is_alu}), 32'(rf));
                check("r_inrange", 32'(exp_pc < PLEN), 32'd1);
            end
            if (halt) begin
                check("r_halt_pc",    32'(exp_pc >= PLEN), 32'd1);
                check("r_halt_valid", 32'(instr_valid),    32'd0);
            end else if (exp_pc >= PLEN) begin
                oob++;
                check("r_halt_late", 32'(oob <= 1), 32'd1);
            end

            r_rst = ($urandom_range(199) == 0) || (halt && ($urandom_range(5) == 0));
            r_rdy = ($urandom_range(3) != 0);
            r_rv  = ($urandom_range(11) == 0);
            r_ra  = 8'($urandom_range(31));
            rst = r_rst; instr_ready = r_rdy; redirect_valid = r_rv; redirect_addr = r_ra;

            if (r_rst) begin
                exp_pc = 0; exp_cnt = 0; oob = 0;
            end else if (!halt) begin
                hs = instr_valid && r_rdy;
                if (hs && exp_cnt < 65535) exp_cnt++;
                if (r_rv) begin
                    exp_pc = int'(r_ra);
                    oob = 0;
                end else if (hs) begin
                    exp_pc = (exp_pc + 1) % 256;
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
